// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit: instruction fetch and decode front end.
//   Presents pc on abus, captures the combinational instruction word from dbus
//   into a one-entry output holding register with valid/ready handshake,
//   splits it into opcode/operand, flags illegal opcodes and out-of-range
//   fetches, and halts on either until redirected.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   enable                  fetching permitted
//   abus / dbus             instruction memory address out / word in
//   inst_valid, inst_ready  issue handshake
//   opcode, operand,        held instruction fields, fetch address and
//   inst_pc, illegal        illegal/fault flag
//   redirect, redirect_addr flush and restart fetch
// Optional macro: FETCH_JMP_FOLD_EN folds jmp into the fetch stage (not issued).
module fetch_decode_unit #(
    parameter logic [12:0] RESET_PC  = 13'h0000,
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [12:0] abus,
    input  logic [15:0] dbus,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [2:0]  opcode,
    output logic [12:0] operand,
    output logic [12:0] inst_pc,
    output logic        illegal,
    input  logic        redirect,
    input  logic [12:0] redirect_addr
);

    localparam int unsigned AW   = 13;
    localparam int unsigned OPW  = 3;
    localparam int unsigned CMPW = AW + 1;

    localparam logic [OPW-1:0] OP_ILL = 3'b111;
`ifdef FETCH_JMP_FOLD_EN
    localparam logic [OPW-1:0] OP_JMP = 3'b100;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_e;

    state_e         state_q;
    logic [AW-1:0]  pc_q;
    logic           valid_q;
    logic [OPW-1:0] opcode_q;
    logic [AW-1:0]  operand_q;
    logic [AW-1:0]  inst_pc_q;
    logic           illegal_q;

    logic           capture_c;
    logic           fault_c;
    logic [OPW-1:0] dbus_op_c;
    logic [AW-1:0]  dbus_arg_c;

    // Holding register is free when empty or being drained this cycle.
    assign capture_c  = (state_q == FETCH) && (!valid_q || inst_ready) && !redirect;
    // One extra bit so MEM_DEPTH = 8192 compares correctly.
    assign fault_c    = {1'b0, pc_q} >= CMPW'(MEM_DEPTH);
    assign dbus_op_c  = dbus[15:13];
    assign dbus_arg_c = dbus[12:0];

    // State, pc and output holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            operand_q <= '0;
            inst_pc_q <= '0;
            illegal_q <= 1'b0;
        end else if (redirect) begin
            pc_q    <= redirect_addr;
            valid_q <= 1'b0;
            state_q <= enable ? FETCH : IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enable)  state_q <= FETCH;
                FETCH:   if (!enable) state_q <= IDLE;
                default: ;
            endcase

            if (capture_c) begin
                inst_pc_q <= pc_q;
                pc_q      <= pc_q + AW'(1);
                valid_q   <= 1'b1;
                if (fault_c) begin
                    // Out-of-range fetch: dbus is meaningless, issue a null word.
                    opcode_q  <= '0;
                    operand_q <= '0;
                    illegal_q <= 1'b1;
                    state_q   <= HALT;
                end else if (dbus_op_c == OP_ILL) begin
                    opcode_q  <= dbus_op_c;
                    operand_q <= dbus_arg_c;
                    illegal_q <= 1'b1;
                    state_q   <= HALT;
                end
`ifdef FETCH_JMP_FOLD_EN
                else if (dbus_op_c == OP_JMP) begin
                    // Jump resolved here: drop it and fetch from its target.
                    valid_q <= 1'b0;
                    pc_q    <= dbus_arg_c;
                end
`endif
                else begin
                    opcode_q  <= dbus_op_c;
                    operand_q <= dbus_arg_c;
                    illegal_q <= 1'b0;
                end
            end else if (inst_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign abus       = pc_q;
    assign inst_valid = valid_q;
    assign opcode     = opcode_q;
    assign operand    = operand_q;
    assign inst_pc    = inst_pc_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: directed scenarios plus randomized traffic,
// checked cycle by cycle against a behavioural model. A second instance with
// an 8192-word memory exercises pc wrap-around.
module tb_fetch_decode_unit;

`ifdef FETCH_JMP_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif
    localparam int MDEPTH = 64;

    logic        clk = 1'b0;
    logic        reset, enable, inst_ready, redirect;
    logic [12:0] redirect_addr;
    logic [12:0] abus, operand, inst_pc;
    logic [15:0] dbus;
    logic [2:0]  opcode;
    logic        inst_valid, illegal;

    logic        w_reset, w_enable, w_ready, w_redirect;
    logic [12:0] w_raddr;
    logic [12:0] w_abus, w_operand, w_inst_pc;
    logic [15:0] w_dbus;
    logic [2:0]  w_opcode;
    logic        w_valid, w_illegal;

    logic [15:0] mem [0:8191];

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state: mode 0 = idle, 1 = fetching, 2 = halted.
    int          m_mode, m_pc;
    bit          m_valid, m_ill;
    int          m_op, m_opd, m_ipc;

    always #5 clk = ~clk;

    assign dbus   = mem[abus];
    assign w_dbus = mem[w_abus];

    fetch_decode_unit #(.RESET_PC(13'h0000), .MEM_DEPTH(MDEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .abus(abus), .dbus(dbus),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .opcode(opcode),
        .operand(operand), .inst_pc(inst_pc), .illegal(illegal),
        .redirect(redirect), .redirect_addr(redirect_addr));

    fetch_decode_unit #(.RESET_PC(13'h0000), .MEM_DEPTH(8192)) dut_w (
        .clk(clk), .reset(w_reset), .enable(w_enable), .abus(w_abus), .dbus(w_dbus),
        .inst_valid(w_valid), .inst_ready(w_ready), .opcode(w_opcode),
        .operand(w_operand), .inst_pc(w_inst_pc), .illegal(w_illegal),
        .redirect(w_redirect), .redirect_addr(w_raddr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next-cycle behaviour computed from the current inputs and model state.
    task automatic model_next();
        int nmode;
        logic [15:0] w;
        int opc;
        if (reset) begin
            m_mode = 0; m_pc = 0; m_valid = 0;
            m_op = 0; m_opd = 0; m_ipc = 0; m_ill = 0;
        end else if (redirect) begin
            m_pc    = int'(redirect_addr);
            m_valid = 0;
            m_mode  = enable ? 1 : 0;
        end else begin
            nmode = m_mode;
            if (m_mode == 0 && enable) nmode = 1;
            if (m_mode == 1 && !enable) nmode = 0;
            if (m_mode == 1 && (!m_valid || inst_ready)) begin
                w   = mem[m_pc];
                opc = int'(w[15:13]);
                if (m_pc >= MDEPTH) begin
                    m_op = 0; m_opd = 0; m_ill = 1; m_valid = 1;
                    m_ipc = m_pc; m_pc = (m_pc + 1) % 8192; nmode = 2;
                end else if (opc == 7) begin
                    m_op = 7; m_opd = int'(w[12:0]); m_ill = 1; m_valid = 1;
                    m_ipc = m_pc; m_pc = (m_pc + 1) % 8192; nmode = 2;
                end else if (FOLD && opc == 4) begin
                    m_valid = 0; m_pc = int'(w[12:0]);
                end else begin
                    m_op = opc; m_opd = int'(w[12:0]); m_ill = 0; m_valid = 1;
                    m_ipc = m_pc; m_pc = (m_pc + 1) % 8192;
                end
            end else if (inst_ready) begin
                m_valid = 0;
            end
            m_mode = nmode;
        end
    endtask

    task automatic check_all();
        chk("abus", 32'(abus), 32'(m_pc));
        chk("inst_valid", 32'(inst_valid), 32'(m_valid));
        if (m_valid) begin
            chk("opcode", 32'(opcode), 32'(m_op));
            chk("operand", 32'(operand), 32'(m_opd));
            chk("inst_pc", 32'(inst_pc), 32'(m_ipc));
            chk("illegal", 32'(illegal), 32'(m_ill));
        end
    endtask

    // One clock: model advances on the same edge as the DUT; sample 1 time unit later.
    task automatic cyc();
        model_next();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input bit r, input bit en, input bit rdy, input bit rd, input int ra);
        reset = r; enable = en; inst_ready = rdy; redirect = rd; redirect_addr = 13'(ra);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        for (int i = 0; i < MDEPTH; i++) mem[i] = {3'b010, 13'(i)};
        mem[0] = 16'hC00A; mem[1] = 16'h2000; mem[2] = 16'h4005;
        mem[11] = 16'h8004; mem[20] = 16'hE000; mem[64] = 16'h1234;
        mem[8191] = 16'h0123;
        w_reset = 1'b1; w_enable = 1'b0; w_ready = 1'b0; w_redirect = 1'b0; w_raddr = '0;
        drive(1, 0, 0, 0, 0);
        #1;
        cyc(); cyc();
        chk("rst_abus", 32'(abus), 32'h0);
        chk("rst_opcode", 32'(opcode), 32'h0);
        chk("rst_inst_pc", 32'(inst_pc), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);

        // Basic stream: capture two cycles after enabling from reset.
        drive(0, 1, 1, 0, 0);
        cyc();
        chk("first_valid_early", 32'(inst_valid), 32'h0);
        cyc();
        chk("c2_opcode", 32'(opcode), 32'h6);
        chk("c2_operand", 32'(operand), 32'h00A);
        chk("c2_inst_pc", 32'(inst_pc), 32'h0);
        cyc();
        chk("c3_opcode", 32'(opcode), 32'h1);
        chk("c3_inst_pc", 32'(inst_pc), 32'h1);

        // Stall for three cycles, then resume with no gap.
        inst_ready = 1'b0;
        cyc(); cyc(); cyc();
        chk("stall_inst_pc", 32'(inst_pc), 32'h1);
        chk("stall_abus", 32'(abus), 32'h2);
        inst_ready = 1'b1;
        cyc();
        chk("resume_inst_pc", 32'(inst_pc), 32'h2);
        chk("resume_valid", 32'(inst_valid), 32'h1);

        // Redirect while holding an instruction.
        drive(0, 1, 0, 1, 4);
        cyc();
        chk("redir_valid", 32'(inst_valid), 32'h0);
        chk("redir_abus", 32'(abus), 32'h4);
        drive(0, 1, 1, 0, 0);
        cyc();
        chk("redir_inst_pc", 32'(inst_pc), 32'h4);

        // jmp at address 11.
        drive(0, 1, 1, 1, 11);
        cyc();
        drive(0, 1, 1, 0, 0);
        cyc();
        if (FOLD) begin
            chk("fold_valid", 32'(inst_valid), 32'h0);
            chk("fold_abus", 32'(abus), 32'h4);
            cyc();
            chk("fold_next_pc", 32'(inst_pc), 32'h4);
        end else begin
            chk("jmp_opcode", 32'(opcode), 32'h4);
            chk("jmp_operand", 32'(operand), 32'h4);
            chk("jmp_inst_pc", 32'(inst_pc), 32'hB);
            cyc();
            chk("jmp_next_pc", 32'(inst_pc), 32'hC);
        end

        // Illegal opcode halts; redirect to 0 resumes.
        drive(0, 1, 1, 1, 20);
        cyc();
        drive(0, 1, 1, 0, 0);
        cyc();
        chk("ill_flag", 32'(illegal), 32'h1);
        chk("ill_opcode", 32'(opcode), 32'h7);
        chk("ill_valid", 32'(inst_valid), 32'h1);
        cyc(); cyc(); cyc();
        chk("halt_valid", 32'(inst_valid), 32'h0);
        chk("halt_abus", 32'(abus), 32'h15);
        drive(0, 1, 1, 1, 0);
        cyc();
        drive(0, 1, 1, 0, 0);
        cyc();
        chk("resume_ill", 32'(illegal), 32'h0);
        chk("resume_pc0", 32'(inst_pc), 32'h0);

        // Out-of-range fetch at MEM_DEPTH.
        drive(0, 1, 1, 1, 64);
        cyc();
        drive(0, 1, 1, 0, 0);
        cyc();
        chk("fault_illegal", 32'(illegal), 32'h1);
        chk("fault_opcode", 32'(opcode), 32'h0);
        chk("fault_operand", 32'(operand), 32'h0);
        chk("fault_inst_pc", 32'(inst_pc), 32'h40);
        cyc(); cyc();
        chk("fault_halt_abus", 32'(abus), 32'h41);

        // Reset overrides redirect, enable and ready.
        drive(1, 1, 1, 1, 5);
        cyc();
        chk("rst_over_abus", 32'(abus), 32'h0);
        chk("rst_over_valid", 32'(inst_valid), 32'h0);

        // pc wrap on the full-depth instance (main instance held in reset).
        w_reset = 1'b0; w_enable = 1'b1; w_ready = 1'b1; w_redirect = 1'b1; w_raddr = 13'h1FFF;
        cyc();
        w_redirect = 1'b0;
        cyc();
        chk("wrap_abus", 32'(w_abus), 32'h0);
        chk("wrap_inst_pc", 32'(w_inst_pc), 32'h1FFF);
        chk("wrap_valid", 32'(w_valid), 32'h1);
        chk("wrap_opcode", 32'(w_opcode), 32'h0);
        w_reset = 1'b1;

        // Randomized traffic over a random program.
        for (int i = 0; i < 80; i++) begin
            int r;
            int opc;
            int arg;
            r   = int'($urandom_range(0, 19));
            opc = (r == 0) ? 7 : (r % 7);
            arg = (opc == 4) ? int'($urandom_range(0, 70)) : int'($urandom_range(0, 8191));
            mem[i] = {3'(opc), 13'(arg)};
        end
        drive(0, 1, 1, 0, 0);
        cyc();
        for (int i = 0; i < 600; i++) begin
            bit rb, eb, yb, db;
            rb = ($urandom_range(0, 99) == 0);
            eb = ($urandom_range(0, 9) != 0);
            yb = ($urandom_range(0, 9) < 7);
            db = ($urandom_range(0, 19) == 0);
            drive(rb, eb, yb, db, int'($urandom_range(0, 66)));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode_unit.md
FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 13'h0000, the fetch address loaded on reset.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 64, the number of valid instruction words; any pc >= MEM_DEPTH is a fault.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  1 = fetching permitted.
REQ-006 abus  out  13  instruction-memory address, SHALL equal pc combinationally.
REQ-007 dbus  in  16  instruction word, combinational read of abus.
REQ-008 inst_valid  out  1  decoded instruction present on outputs.
REQ-009 inst_ready  in  1  consumer accepts the instruction this cycle.
REQ-010 opcode  out  3  dbus[15:13] of the held instruction.
REQ-011 operand  out  13  dbus[12:0] of the held instruction.
REQ-012 inst_pc  out  13  address the held instruction was fetched from.
REQ-013 illegal  out  1  held instruction has opcode 3'b111 or fetch fault.
REQ-014 redirect  in  1  flush and restart fetch at redirect_addr.
REQ-015 redirect_addr  in  13  new fetch address.

Function
REQ-016 States SHALL be IDLE, FETCH, HALT; reset enters IDLE.
REQ-017 IDLE->FETCH when enable=1; FETCH->IDLE when enable=0; HALT exits only on redirect or reset.
REQ-018 Capture condition: state FETCH and (inst_valid=0 or inst_ready=1) and redirect=0.
REQ-019 On capture, output registers SHALL load {opcode,operand}=dbus, inst_pc=pc, inst_valid=1, and pc SHALL become pc+1 modulo 2^13 (8191 wraps to 0).
REQ-020 Latency: the word at abus=N SHALL appear on outputs, inst_valid=1, on the edge following the capture cycle.
REQ-021 When inst_valid=1 and inst_ready=0, all outputs and pc SHALL hold unchanged.
REQ-022 When inst_ready=1 and no capture occurs (IDLE/HALT), inst_valid SHALL clear on the next edge.
REQ-023 Accept and capture in the same cycle SHALL give back-to-back issue, one instruction per cycle.
REQ-024 redirect=1 SHALL have priority over all else: next edge pc=redirect_addr, inst_valid=0, any held instruction discarded; state FETCH if enable=1, else IDLE.
REQ-025 A captured opcode 3'b111 SHALL set illegal=1 with inst_valid=1 and move the state to HALT.
REQ-026 Capture with pc >= MEM_DEPTH SHALL present opcode=0, operand=0, illegal=1, inst_valid=1, ignore dbus, and move to HALT.
REQ-027 Opcodes 000-110 (lda, sta, add, sub, jmp, jez, ldi) SHALL be issued with illegal=0; jez is issued unchanged and resolved downstream via redirect.

Reset
REQ-028 Reset SHALL set pc=RESET_PC, state=IDLE, inst_valid=0, opcode=0, operand=0, inst_pc=0, illegal=0.
REQ-029 Reset SHALL override redirect, enable and inst_ready in the same cycle; an in-flight instruction is dropped.

Configuration
REQ-030 With macro FETCH_JMP_FOLD_EN defined, a captured jmp (3'b100) SHALL NOT be issued: inst_valid becomes 0 and pc becomes operand on the next edge, one bubble cycle.
REQ-031 Without FETCH_JMP_FOLD_EN, jmp SHALL be issued like any other opcode and pc SHALL increment normally.

Verification
REQ-032 Reset, enable=1, inst_ready=1, memory 0:C00A 1:2000 -> cycle 2 opcode=110 operand=00A inst_pc=0; cycle 3 opcode=001 operand=000 inst_pc=1.
REQ-033 inst_ready=0 for 3 cycles with inst_valid=1 -> outputs and abus stable; on ready=1, next instruction follows with no gap.
REQ-034 redirect=1, redirect_addr=0004 while holding an instruction -> next edge inst_valid=0, abus=0004; following edge inst_pc=0004.
REQ-035 Word 8004 at address 11: with FETCH_JMP_FOLD_EN, no instruction for inst_pc=11 issued, next inst_pc=4; without, opcode=100 operand=0004 issued, next inst_pc=12.
REQ-036 Word E000, or pc=64 with MEM_DEPTH=64 -> illegal=1, state HALT, no further captures; redirect to 0 resumes fetch.
REQ-037 redirect_addr=1FFF, memory model covering 8192 words, MEM_DEPTH=8192 -> after capture at 1FFF, abus=0000.
